// File: rtl/reg_rd.sv
// Read-back responder for the coefficient register bank: one outstanding read,
// full-width address decode, snapshotted response with valid/accept handshake.
module reg_rd #(
   parameter int unsigned    DW     = 8,
   parameter int unsigned    AW     = 32,
   parameter int unsigned    NREG   = 4,
   parameter logic [AW-1:0]  BASE   = AW'(32'h1000_1234),
   parameter int unsigned    STRIDE = 1,
   parameter int unsigned    OREG   = 1
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic                 reg_rea,
   input  logic [AW-1:0]        reg_raddr,
   input  logic [NREG*DW-1:0]   reg_coeff_bus,
   output logic                 reg_rrdy,
   output logic                 reg_rvalid,
   output logic [DW-1:0]        reg_rdata,
   output logic                 reg_rerr,
   input  logic                 reg_racc,
   output logic [7:0]           reg_errcnt
);

   localparam int unsigned OW = AW + 1;
   localparam int unsigned CW = 2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEL  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t          r_state;
   logic [AW-1:0]   r_addr;
   logic [CW-1:0]   r_cnt;
   logic            r_rrdy;
   logic            r_rvalid;
   logic [DW-1:0]   r_rdata;
   logic            r_rerr;
   logic [7:0]      r_errcnt;

   logic [OW-1:0]   w_off;
   logic            w_hit;
   logic [DW-1:0]   w_data;

   // Decode: an address below BASE borrows into the top bit and matches no slot.
   always_comb begin
      w_off  = {1'b0, r_addr} - {1'b0, BASE};
      w_hit  = 1'b0;
      w_data = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (w_off == OW'(i * STRIDE)) begin
            w_hit  = 1'b1;
            w_data = reg_coeff_bus[i*DW +: DW];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         r_state  <= S_IDLE;
         r_addr   <= '0;
         r_cnt    <= '0;
         r_rrdy   <= 1'b0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         r_rerr   <= 1'b0;
         r_errcnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_rrdy && reg_rea) begin
                  r_addr  <= reg_raddr;
                  r_rrdy  <= 1'b0;
                  r_state <= S_SEL;
               end else begin
                  r_rrdy  <= 1'b1;
               end
            end
            S_SEL: begin
               r_rdata <= w_hit ? w_data : '0;
               r_rerr  <= ~w_hit;
               if (!w_hit && (r_errcnt != 8'hFF)) begin
                  r_errcnt <= r_errcnt + 8'd1;
               end
               if (OREG == 0) begin
                  r_rvalid <= 1'b1;
                  r_state  <= S_RESP;
               end else begin
                  r_cnt    <= CW'(OREG - 1);
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == '0) begin
                  r_rvalid <= 1'b1;
                  r_state  <= S_RESP;
               end else begin
                  r_cnt    <= r_cnt - CW'(1);
               end
            end
            S_RESP: begin
               // Response data is held until the host takes it.
               if (reg_racc) begin
                  r_rvalid <= 1'b0;
                  r_rrdy   <= 1'b1;
                  r_state  <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign reg_rrdy   = r_rrdy;
   assign reg_rvalid = r_rvalid;
   assign reg_rdata  = r_rdata;
   assign reg_rerr   = r_rerr;
   assign reg_errcnt = r_errcnt;

endmodule
